// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, RV32I opcode and funct3 constants
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational RV32I decode to ALU control and datapath selects
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_control_o,
  output logic       use_imm_o,
  output logic       is_shift_o,
  output logic       regwrite_o,
  output logic       is_branch_o,
  output logic       branch_ne_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_NOP;
    use_imm_o     = 1'b0;
    is_shift_o    = 1'b0;
    regwrite_o    = 1'b0;
    is_branch_o   = 1'b0;
    branch_ne_o   = 1'b0;
    illegal_o     = 1'b0;
    case (opcode_i)
      OP_R, OP_I: begin
        regwrite_o = 1'b1;
        use_imm_o  = (opcode_i == OP_I);
        case (funct3_i)
          // Immediate form has no SUBI: bit 30 is part of the immediate there
          F3_ADD: alu_control_o = (opcode_i == OP_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          F3_SLL: begin
            alu_control_o = ALU_SLL;
            is_shift_o    = 1'b1;
          end
          F3_XOR: alu_control_o = ALU_XOR;
          F3_OR:  alu_control_o = ALU_OR;
          F3_AND: alu_control_o = ALU_AND;
          F3_SR: begin
            alu_control_o = funct7_5_i ? ALU_SRA : ALU_SRL;
            is_shift_o    = 1'b1;
          end
          default: begin
            illegal_o  = 1'b1;
            regwrite_o = 1'b0;
            use_imm_o  = 1'b0;
          end
        endcase
      end
      OP_LOAD: begin
        alu_control_o = ALU_ADD;
        use_imm_o     = 1'b1;
        regwrite_o    = 1'b1;
      end
      OP_STORE: begin
        alu_control_o = ALU_ADD;
        use_imm_o     = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3_i == F3_BEQ || funct3_i == F3_BNE) begin
          alu_control_o = ALU_SUB;
          is_branch_o   = 1'b1;
          branch_ne_o   = (funct3_i == F3_BNE);
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand forwarding, ID/EX register and BEQ/BNE resolution
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic              exmem_regwrite,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [XLEN-1:0]   memwb_result,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              alu_zero,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_control,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_is_branch,
  output logic              ex_branch_ne,
  output logic [REG_AW-1:0] ex_rd,
  output logic              branch_taken,
  output logic [XLEN-1:0]   branch_target,
  output logic              illegal_insn
);

  logic [3:0] dec_control;
  logic       dec_use_imm, dec_is_shift, dec_regwrite, dec_is_branch, dec_branch_ne, dec_illegal;

  alu_ctrl_decode u_decode (
    .opcode_i      (opcode),
    .funct3_i      (funct3),
    .funct7_5_i    (funct7_5),
    .alu_control_o (dec_control),
    .use_imm_o     (dec_use_imm),
    .is_shift_o    (dec_is_shift),
    .regwrite_o    (dec_regwrite),
    .is_branch_o   (dec_is_branch),
    .branch_ne_o   (dec_branch_ne),
    .illegal_o     (dec_illegal)
  );

  logic [XLEN-1:0] fwd_a, fwd_b, operand_b, operand_b_sh;

  assign fwd_a = (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs1_addr) ? exmem_result :
                 (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs1_addr) ? memwb_result :
                 rs1_data;
  assign fwd_b = (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs2_addr) ? exmem_result :
                 (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs2_addr) ? memwb_result :
                 rs2_data;
  assign operand_b    = dec_use_imm ? imm : fwd_b;
  assign operand_b_sh = dec_is_shift ? {{(XLEN-5){1'b0}}, operand_b[4:0]} : operand_b;

  logic              valid_q, regwrite_q, is_branch_q, branch_ne_q;
  logic              valid_d, regwrite_d, is_branch_d, branch_ne_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, pc_q, pc_d, imm_q, imm_d;
  logic [3:0]        control_q, control_d;
  logic              taken_q, taken_d, illegal_q, illegal_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              resolve;

  // A stalled branch cannot resolve, so it fires once on its first free cycle
  assign resolve = valid_q && is_branch_q && !stall_in && !flush_in;

  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    is_branch_d = is_branch_q;
    branch_ne_d = branch_ne_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    control_d   = control_q;
    taken_d     = resolve && (alu_zero ^ branch_ne_q);
    target_d    = taken_d ? pc_q + imm_q : '0;
    illegal_d   = in_valid && dec_illegal && !stall_in && !flush_in;
    if (!flush_in && !taken_d && stall_in) begin
      // hold everything
    end else if (!flush_in && !taken_d && in_valid && !dec_illegal) begin
      valid_d     = 1'b1;
      regwrite_d  = dec_regwrite;
      is_branch_d = dec_is_branch;
      branch_ne_d = dec_branch_ne;
      rd_d        = rd_addr;
      a_d         = fwd_a;
      b_d         = operand_b_sh;
      pc_d        = pc;
      imm_d       = imm;
      control_d   = dec_control;
    end else begin
      valid_d     = 1'b0;
      regwrite_d  = 1'b0;
      is_branch_d = 1'b0;
      branch_ne_d = 1'b0;
      rd_d        = '0;
      a_d         = '0;
      b_d         = '0;
      pc_d        = '0;
      imm_d       = '0;
      control_d   = ALU_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      is_branch_q <= 1'b0;
      branch_ne_q <= 1'b0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      control_q   <= 4'b0000;
      taken_q     <= 1'b0;
      target_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      is_branch_q <= is_branch_d;
      branch_ne_q <= branch_ne_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      control_q   <= control_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready      = !stall_in;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_control   = control_q;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_is_branch  = is_branch_q;
  assign ex_branch_ne  = branch_ne_q;
  assign ex_rd         = rd_q;
  assign branch_taken  = taken_q;
  assign branch_target = target_q;
  assign illegal_insn  = illegal_q;

endmodule
